// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared NoC constants, header field layout and FSM encoding
package noc_pkg;

    localparam int Noc_Data_Width = 32;

    // Default field widths used by NoC blocks
    localparam int NOC_COORD_W = 4;
    localparam int NOC_LEN_W   = 8;

    // Header field positions, counted in units of the coordinate width
    localparam int HDR_DEST_X_SLOT = 0;
    localparam int HDR_DEST_Y_SLOT = 1;
    localparam int HDR_SRC_X_SLOT  = 2;
    localparam int HDR_SRC_Y_SLOT  = 3;
    localparam int HDR_LEN_SLOT    = 4;

    // Bit offset of a header field given its slot and the coordinate width
    function automatic int hdr_lsb(input int slot, input int coord_w);
        return slot * coord_w;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAD = 2'd1,
        ST_BODY = 2'd2
    } noc_state_e;

endpackage

// File: rtl/noc_sync_fifo.sv
// rtl/noc_sync_fifo.sv - synchronous FIFO with combinational head, shared by NoC buffers
module noc_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    // Full is taken from the registered pointers, so a pop does not make room in the same cycle
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    // Pointer update; reset flushes the FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write; contents need no reset because the pointers gate visibility
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/noc_local_packetizer.sv
// rtl/noc_local_packetizer.sv - builds header+payload wormhole packets for a router local port
module noc_local_packetizer
    import noc_pkg::*;
#(
    parameter int X_ID       = 0,
    parameter int Y_ID       = 0,
    parameter int DATA_WIDTH = Noc_Data_Width,
    parameter int COORD_W    = 4,
    parameter int LEN_W      = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  noc_clk,
    input  logic                  noc_rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [COORD_W-1:0]    req_dest_x,
    input  logic [COORD_W-1:0]    req_dest_y,
    input  logic [LEN_W-1:0]      req_len,
    input  logic                  data_valid,
    output logic                  data_ready,
    input  logic [DATA_WIDTH-1:0] data_word,
    output logic                  sender_valid,
    input  logic                  sender_ready,
    output logic [DATA_WIDTH-1:0] sender_flit,
    output logic                  sender_is_header,
    output logic                  sender_is_tail,
    output logic [15:0]           pkt_count
);

    localparam logic [COORD_W-1:0] SRC_X = COORD_W'(X_ID);
    localparam logic [COORD_W-1:0] SRC_Y = COORD_W'(Y_ID);
    localparam int DEST_X_LSB = hdr_lsb(HDR_DEST_X_SLOT, COORD_W);
    localparam int DEST_Y_LSB = hdr_lsb(HDR_DEST_Y_SLOT, COORD_W);
    localparam int SRC_X_LSB  = hdr_lsb(HDR_SRC_X_SLOT, COORD_W);
    localparam int SRC_Y_LSB  = hdr_lsb(HDR_SRC_Y_SLOT, COORD_W);
    localparam int LEN_LSB    = hdr_lsb(HDR_LEN_SLOT, COORD_W);

    noc_state_e            state_q;
    noc_state_e            state_d;
    logic [COORD_W-1:0]    dest_x_q;
    logic [COORD_W-1:0]    dest_y_q;
    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      remaining_q;
    logic [15:0]           pkt_count_q;
    logic [DATA_WIDTH-1:0] header;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic                  req_fire;
    logic                  head_fire;
    logic                  body_fire;
    logic                  last_body;
    logic                  pkt_done;

    // Payload buffer fills regardless of packet state so data may run ahead of requests
    noc_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_payload_fifo (
        .clk       (noc_clk),
        .rst_n     (noc_rst_n),
        .push      (data_valid),
        .push_data (data_word),
        .pop       (body_fire),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    assign data_ready = !fifo_full;
    assign req_fire   = (state_q == ST_IDLE) && req_valid;
    assign head_fire  = (state_q == ST_HEAD) && sender_ready;
    assign body_fire  = (state_q == ST_BODY) && sender_ready && !fifo_empty;
    assign last_body  = (remaining_q == LEN_W'(1));
    assign pkt_done   = (head_fire && (len_q == '0)) || (body_fire && last_body);
    assign pkt_count  = pkt_count_q;

    // Assemble the header flit from the latched request and this node's coordinates
    always_comb begin
        header = '0;
        header[DEST_X_LSB +: COORD_W] = dest_x_q;
        header[DEST_Y_LSB +: COORD_W] = dest_y_q;
        header[SRC_X_LSB  +: COORD_W] = SRC_X;
        header[SRC_Y_LSB  +: COORD_W] = SRC_Y;
        header[LEN_LSB    +: LEN_W]   = len_q;
    end

    // State register
    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) state_q <= ST_IDLE;
        else            state_q <= state_d;
    end

    // Next-state: one packet in flight, header then len payload flits
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_valid)  state_d = ST_HEAD;
            ST_HEAD: if (head_fire)  state_d = (len_q == '0) ? ST_IDLE : ST_BODY;
            ST_BODY: if (body_fire && last_body) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decode from state only, so reset clears them without waiting for a clock
    always_comb begin
        req_ready        = 1'b0;
        sender_valid     = 1'b0;
        sender_flit      = '0;
        sender_is_header = 1'b0;
        sender_is_tail   = 1'b0;
        case (state_q)
            ST_IDLE: req_ready = 1'b1;
            ST_HEAD: begin
                sender_valid     = 1'b1;
                sender_flit      = header;
                sender_is_header = 1'b1;
                sender_is_tail   = (len_q == '0);
            end
            ST_BODY: begin
                sender_valid   = !fifo_empty;
                sender_flit    = fifo_head;
                sender_is_tail = last_body;
            end
            default: ;
        endcase
    end

    // Request latch, remaining-flit counter and completed-packet counter
    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            dest_x_q    <= '0;
            dest_y_q    <= '0;
            len_q       <= '0;
            remaining_q <= '0;
            pkt_count_q <= '0;
        end else begin
            if (req_fire) begin
                dest_x_q <= req_dest_x;
                dest_y_q <= req_dest_y;
                len_q    <= req_len;
            end
            if (head_fire && (len_q != '0)) remaining_q <= len_q;
            else if (body_fire)              remaining_q <= remaining_q - LEN_W'(1);
            if (pkt_done) pkt_count_q <= pkt_count_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_noc_local_packetizer.sv
// tb/tb_noc_local_packetizer.sv - directed self-checking bench for noc_local_packetizer
module tb_noc_local_packetizer;

    logic        noc_clk = 1'b0;
    logic        noc_rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_dest_x;
    logic [3:0]  req_dest_y;
    logic [7:0]  req_len;
    logic        data_valid;
    logic        data_ready;
    logic [31:0] data_word;
    logic        sender_valid;
    logic        sender_ready;
    logic [31:0] sender_flit;
    logic        sender_is_header;
    logic        sender_is_tail;
    logic [15:0] pkt_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] got_flit[$];
    bit          got_hdr[$];
    bit          got_tail[$];
    logic [31:0] feed_q[$];
    int          stall_changes;
    int          gap_cycles;
    int          pkt_cycles;
    bit          timed_out;

    noc_local_packetizer dut (
        .noc_clk          (noc_clk),
        .noc_rst_n        (noc_rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_dest_x       (req_dest_x),
        .req_dest_y       (req_dest_y),
        .req_len          (req_len),
        .data_valid       (data_valid),
        .data_ready       (data_ready),
        .data_word        (data_word),
        .sender_valid     (sender_valid),
        .sender_ready     (sender_ready),
        .sender_flit      (sender_flit),
        .sender_is_header (sender_is_header),
        .sender_is_tail   (sender_is_tail),
        .pkt_count        (pkt_count)
    );

    always #5 noc_clk = ~noc_clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic tick();
        @(posedge noc_clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w);
        data_valid = 1'b1;
        data_word  = w;
        tick();
        data_valid = 1'b0;
    endtask

    task automatic send_req(input logic [3:0] x, input logic [3:0] y, input logic [7:0] len);
        req_valid  = 1'b1;
        req_dest_x = x;
        req_dest_y = y;
        req_len    = len;
        tick();
        req_valid  = 1'b0;
    endtask

    // Drives sender_ready/payload per cycle and records accepted flits until the tail
    task automatic run_packet(input bit toggle, input int feed_period, input int budget);
        bit          prev_stall = 1'b0;
        logic [31:0] prev_flit  = '0;
        bit          prev_hdr   = 1'b0;
        bit          prev_tail  = 1'b0;
        bit          done;
        got_flit.delete();
        got_hdr.delete();
        got_tail.delete();
        stall_changes = 0;
        gap_cycles    = 0;
        pkt_cycles    = 0;
        timed_out     = 1'b1;
        for (int cyc = 0; cyc < budget; cyc++) begin
            sender_ready = toggle ? ((cyc % 2) == 1) : 1'b1;
            data_valid   = (feed_q.size() > 0) && ((cyc % feed_period) == 0);
            data_word    = data_valid ? feed_q[0] : 32'h0;
            #1;
            if (prev_stall && (!sender_valid || sender_flit !== prev_flit ||
                               sender_is_header !== prev_hdr || sender_is_tail !== prev_tail))
                stall_changes++;
            prev_stall = sender_valid && !sender_ready;
            prev_flit  = sender_flit;
            prev_hdr   = sender_is_header;
            prev_tail  = sender_is_tail;
            if (!sender_valid && got_flit.size() > 0) gap_cycles++;
            done = 1'b0;
            if (sender_valid && sender_ready) begin
                got_flit.push_back(sender_flit);
                got_hdr.push_back(sender_is_header);
                got_tail.push_back(sender_is_tail);
                done = sender_is_tail;
            end
            if (data_valid && data_ready) void'(feed_q.pop_front());
            pkt_cycles++;
            tick();
            data_valid = 1'b0;
            if (done) begin
                timed_out = 1'b0;
                break;
            end
        end
        sender_ready = 1'b0;
    endtask

    task automatic test_reset();
        noc_rst_n    = 1'b0;
        req_valid    = 1'b0;
        req_dest_x   = '0;
        req_dest_y   = '0;
        req_len      = '0;
        data_valid   = 1'b0;
        data_word    = '0;
        sender_ready = 1'b0;
        repeat (3) tick();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset req_ready got %b exp 1", req_ready); end
        checks++; if (data_ready !== 1'b1) begin errors++; $display("FAIL reset data_ready got %b exp 1", data_ready); end
        checks++; if (sender_valid !== 1'b0) begin errors++; $display("FAIL reset sender_valid got %b exp 0", sender_valid); end
        checks++; if (sender_flit !== 32'h0) begin errors++; $display("FAIL reset sender_flit got %h exp 0", sender_flit); end
        checks++; if (sender_is_header !== 1'b0) begin errors++; $display("FAIL reset is_header got %b exp 0", sender_is_header); end
        checks++; if (sender_is_tail !== 1'b0) begin errors++; $display("FAIL reset is_tail got %b exp 0", sender_is_tail); end
        checks++; if (pkt_count !== 16'd0) begin errors++; $display("FAIL reset pkt_count got %0d exp 0", pkt_count); end
        noc_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [31:0] exp_f[$] = '{32'h0003_0011, 32'hA1, 32'hA2, 32'hA3};
        push_word(32'hA1);
        push_word(32'hA2);
        push_word(32'hA3);
        send_req(4'd1, 4'd1, 8'd3);
        run_packet(1'b0, 1, 20);
        checks++; if (timed_out) begin errors++; $display("FAIL basic timeout got %0d flits exp 4", got_flit.size()); end
        for (int i = 0; i < exp_f.size(); i++) begin
            checks++;
            if (i >= got_flit.size() || got_flit[i] !== exp_f[i] || got_hdr[i] !== (i == 0) ||
                got_tail[i] !== (i == exp_f.size() - 1)) begin
                errors++;
                $display("FAIL basic flit%0d got %h h%0b t%0b exp %h", i, got_flit[i], got_hdr[i], got_tail[i], exp_f[i]);
            end
        end
        checks++; if (pkt_cycles !== 4 || gap_cycles !== 0) begin errors++; $display("FAIL basic cycles got %0d gaps %0d exp 4 gaps 0", pkt_cycles, gap_cycles); end
        checks++; if (sender_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL basic idle valid %b ready %b exp 0 1", sender_valid, req_ready); end
        checks++; if (pkt_count !== 16'd1) begin errors++; $display("FAIL basic pkt_count got %0d exp 1", pkt_count); end
    endtask

    task automatic test_len_zero();
        sender_ready = 1'b1;
        send_req(4'd2, 4'd3, 8'd0);
        #1;
        checks++;
        if (sender_valid !== 1'b1 || sender_flit !== 32'h0000_0032 || sender_is_header !== 1'b1 || sender_is_tail !== 1'b1) begin
            errors++;
            $display("FAIL len0 flit got v%b %h h%b t%b exp v1 00000032 h1 t1", sender_valid, sender_flit, sender_is_header, sender_is_tail);
        end
        tick();
        sender_ready = 1'b0;
        #1;
        checks++; if (sender_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL len0 idle valid %b ready %b exp 0 1", sender_valid, req_ready); end
        checks++; if (pkt_count !== 16'd2) begin errors++; $display("FAIL len0 pkt_count got %0d exp 2", pkt_count); end
    endtask

    task automatic test_stall();
        logic [31:0] exp_f[$] = '{32'h0004_0065, 32'hB1, 32'hB2, 32'hB3, 32'hB4};
        push_word(32'hB1);
        push_word(32'hB2);
        push_word(32'hB3);
        push_word(32'hB4);
        send_req(4'd5, 4'd6, 8'd4);
        run_packet(1'b1, 1, 40);
        checks++; if (timed_out || got_flit.size() != 5) begin errors++; $display("FAIL stall count got %0d exp 5", got_flit.size()); end
        for (int i = 0; i < exp_f.size(); i++) begin
            checks++;
            if (i >= got_flit.size() || got_flit[i] !== exp_f[i] || got_hdr[i] !== (i == 0) ||
                got_tail[i] !== (i == exp_f.size() - 1)) begin
                errors++;
                $display("FAIL stall flit%0d got %h h%0b t%0b exp %h", i, got_flit[i], got_hdr[i], got_tail[i], exp_f[i]);
            end
        end
        checks++; if (stall_changes !== 0) begin errors++; $display("FAIL stall stability got %0d changes exp 0", stall_changes); end
        checks++; if (pkt_cycles !== 10) begin errors++; $display("FAIL stall cycles got %0d exp 10", pkt_cycles); end
        checks++; if (pkt_count !== 16'd3) begin errors++; $display("FAIL stall pkt_count got %0d exp 3", pkt_count); end
    endtask

    task automatic test_late_payload();
        logic [31:0] exp_f[$] = '{32'h0003_0023, 32'h51, 32'h52, 32'h53};
        send_req(4'd3, 4'd2, 8'd3);
        feed_q = '{32'h51, 32'h52, 32'h53};
        run_packet(1'b0, 3, 40);
        checks++; if (timed_out || got_flit.size() != 4) begin errors++; $display("FAIL late count got %0d exp 4", got_flit.size()); end
        for (int i = 0; i < exp_f.size(); i++) begin
            checks++;
            if (i >= got_flit.size() || got_flit[i] !== exp_f[i] || got_hdr[i] !== (i == 0) ||
                got_tail[i] !== (i == exp_f.size() - 1)) begin
                errors++;
                $display("FAIL late flit%0d got %h h%0b t%0b exp %h", i, got_flit[i], got_hdr[i], got_tail[i], exp_f[i]);
            end
        end
        checks++; if (gap_cycles !== 4 || pkt_cycles !== 8) begin errors++; $display("FAIL late gaps got %0d cycles %0d exp 4 8", gap_cycles, pkt_cycles); end
        checks++; if (pkt_count !== 16'd4) begin errors++; $display("FAIL late pkt_count got %0d exp 4", pkt_count); end
    endtask

    task automatic test_fifo_full();
        logic [31:0] exp_f[$] = '{32'h0008_0000, 32'hC1, 32'hC2, 32'hC3, 32'hC4, 32'hC5, 32'hC6, 32'hC7, 32'hC8};
        for (int i = 0; i < 8; i++) begin
            data_valid = 1'b1;
            data_word  = 32'hC1 + i;
            #1;
            checks++; if (data_ready !== 1'b1) begin errors++; $display("FAIL full ready_before word%0d got %b exp 1", i, data_ready); end
            tick();
        end
        data_word = 32'hC9;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL full ready_when_full cyc%0d got %b exp 0", i, data_ready); end
            tick();
        end
        data_valid = 1'b0;
        send_req(4'd0, 4'd0, 8'd8);
        feed_q = '{32'hC9};
        run_packet(1'b0, 1, 30);
        checks++; if (timed_out || got_flit.size() != 9) begin errors++; $display("FAIL full count got %0d exp 9", got_flit.size()); end
        for (int i = 0; i < exp_f.size(); i++) begin
            checks++;
            if (i >= got_flit.size() || got_flit[i] !== exp_f[i] || got_hdr[i] !== (i == 0) ||
                got_tail[i] !== (i == exp_f.size() - 1)) begin
                errors++;
                $display("FAIL full flit%0d got %h h%0b t%0b exp %h", i, got_flit[i], got_hdr[i], got_tail[i], exp_f[i]);
            end
        end
        checks++; if (feed_q.size() != 0) begin errors++; $display("FAIL full ninth_accepted left %0d exp 0", feed_q.size()); end
        feed_q.delete();
        send_req(4'd7, 4'd7, 8'd1);
        run_packet(1'b0, 1, 20);
        checks++;
        if (timed_out || got_flit.size() != 2 || got_flit[0] !== 32'h0001_0077 || got_flit[1] !== 32'hC9 || got_tail[1] !== 1'b1) begin
            errors++;
            $display("FAIL full ninth_packet got n%0d %h %h exp 2 00010077 000000c9", got_flit.size(), got_flit[0], got_flit[1]);
        end
        checks++; if (pkt_count !== 16'd6) begin errors++; $display("FAIL full pkt_count got %0d exp 6", pkt_count); end
    endtask

    task automatic test_reset_mid_packet();
        for (int i = 0; i < 5; i++) push_word(32'hD1 + i);
        sender_ready = 1'b1;
        send_req(4'd4, 4'd4, 8'd5);
        tick();
        tick();
        checks++; if (sender_valid !== 1'b1 || sender_flit !== 32'hD2) begin errors++; $display("FAIL rst pre_state got v%b %h exp v1 000000d2", sender_valid, sender_flit); end
        tick();
        noc_rst_n = 1'b0;
        #1;
        checks++;
        if (sender_valid !== 1'b0 || sender_flit !== 32'h0 || sender_is_header !== 1'b0 || sender_is_tail !== 1'b0) begin
            errors++;
            $display("FAIL rst async_outputs got v%b %h h%b t%b exp all 0", sender_valid, sender_flit, sender_is_header, sender_is_tail);
        end
        checks++;
        if (pkt_count !== 16'd0 || req_ready !== 1'b1 || data_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst async_status got cnt %0d rr %b dr %b exp 0 1 1", pkt_count, req_ready, data_ready);
        end
        sender_ready = 1'b0;
        tick();
        noc_rst_n = 1'b1;
        tick();
        push_word(32'hE1);
        send_req(4'd2, 4'd1, 8'd1);
        run_packet(1'b0, 1, 20);
        checks++;
        if (timed_out || got_flit.size() != 2 || got_flit[0] !== 32'h0001_0012 || got_hdr[0] !== 1'b1 ||
            got_flit[1] !== 32'hE1 || got_tail[1] !== 1'b1) begin
            errors++;
            $display("FAIL rst fresh_packet got n%0d %h %h exp 2 00010012 000000e1", got_flit.size(), got_flit[0], got_flit[1]);
        end
        checks++; if (pkt_count !== 16'd1) begin errors++; $display("FAIL rst pkt_count got %0d exp 1", pkt_count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len_zero();
        test_stall();
        test_late_payload();
        test_fifo_full();
        test_reset_mid_packet();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
